// File: rtl/mult_pkg.sv
// Shared definitions for the repeated-addition multiplier: datapath width and controller states.
package mult_pkg;

  localparam int unsigned DATA_W = 16;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLoadA = 3'd1,
    StLoadB = 3'd2,
    StLoop  = 3'd3,
    StDone  = 3'd4
  } state_e;

endpackage

// File: rtl/multiply_controller.sv
// Control FSM for the repeated-addition multiplier: handshakes A then B in, steps P += A /
// B -= 1 until the datapath reports eqz, and keeps a saturating count of loop iterations.
module multiply_controller
  import mult_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             eqz,
  output logic             LdA,
  output logic             LdB,
  output logic             LdP,
  output logic             clrP,
  output logic             decB,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] iter_count
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               cnt_clr, cnt_inc;

  // Mealy decode: strobes follow in_valid/eqz in the same cycle.
  always_comb begin
    state_d  = state_q;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    in_ready = 1'b0;
    LdA      = 1'b0;
    LdB      = 1'b0;
    LdP      = 1'b0;
    clrP     = 1'b0;
    decB     = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoadA;
          cnt_clr = 1'b1;
        end
      end
      StLoadA: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        LdA      = in_valid;
        if (in_valid) state_d = StLoadB;
      end
      StLoadB: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        LdB      = in_valid;
        clrP     = in_valid;
        if (in_valid) state_d = StLoop;
      end
      StLoop: begin
        busy = 1'b1;
        if (!eqz) begin
          LdP     = 1'b1;
          decB    = 1'b1;
          cnt_inc = 1'b1;
        end else begin
          state_d = StDone;
        end
      end
      StDone: begin
        done = 1'b1;
        if (start) begin
          state_d = StLoadA;
          cnt_clr = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // The datapath must never be written while reset is asserted.
    if (rst) begin
      in_ready = 1'b0;
      LdA      = 1'b0;
      LdB      = 1'b0;
      LdP      = 1'b0;
      clrP     = 1'b0;
      decB     = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (cnt_inc && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign iter_count = rst ? '0 : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multiply_controller.sv
// Bench for multiply_controller: two instances (CNT_W 16 and 4) driven in lockstep, each with
// a behavioural datapath built from its strobes.
module tb_multiply_controller;

  logic        clk = 1'b0;
  logic        rst, start, in_valid;
  logic [15:0] data;

  logic        rdy16, lda16, ldb16, ldp16, clrp16, decb16, busy16, done16;
  logic [15:0] iter16;
  logic        rdy4, lda4, ldb4, ldp4, clrp4, decb4, busy4, done4;
  logic [3:0]  iter4;

  logic [15:0] a16 = '0, b16 = '0, p16 = '0;
  logic [15:0] a4 = '0, b4 = '0, p4 = '0;
  logic        eqz16, eqz4;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign eqz16 = (b16 == 16'd0);
  assign eqz4  = (b4 == 16'd0);

  multiply_controller #(.CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy16), .eqz(eqz16),
    .LdA(lda16), .LdB(ldb16), .LdP(ldp16), .clrP(clrp16), .decB(decb16), .busy(busy16),
    .done(done16), .iter_count(iter16)
  );

  multiply_controller #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(rdy4), .eqz(eqz4),
    .LdA(lda4), .LdB(ldb4), .LdP(ldp4), .clrP(clrp4), .decB(decb4), .busy(busy4),
    .done(done4), .iter_count(iter4)
  );

  always @(posedge clk) begin
    if (lda16) a16 <= data;
    if (ldb16) b16 <= data;
    else if (decb16) b16 <= b16 - 16'd1;
    if (clrp16) p16 <= '0;
    else if (ldp16) p16 <= p16 + a16;
    if (lda4) a4 <= data;
    if (ldb4) b4 <= data;
    else if (decb4) b4 <= b4 - 16'd1;
    if (clrp4) p4 <= '0;
    else if (ldp4) p4 <= p4 + a4;
  end

  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("excl16", {31'd0, (lda16 & ldb16) | (lda16 & ldp16) | (ldb16 & ldp16) |
                            (clrp16 & ldp16)}, 32'd0);
      chk("excl4", {31'd0, (lda4 & ldb4) | (lda4 & ldp4) | (ldb4 & ldp4) |
                           (clrp4 & ldp4)}, 32'd0);
    end
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    int          gap;
    bit          poke;
    int          abort;
    logic [15:0] exp_p;
    int          exp_cnt16;
    int          exp_cnt4;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"}, {31'd0, rdy16 | rdy4}, 32'd0);
    chk({tag, "_ld"}, {28'd0, lda16 | lda4, ldb16 | ldb4, ldp16 | ldp4, clrp16 | clrp4}, 32'd0);
    chk({tag, "_decb"}, {31'd0, decb16 | decb4}, 32'd0);
    chk({tag, "_busy_done"}, {30'd0, busy16 | busy4, done16 | done4}, 32'd0);
    chk({tag, "_iter16"}, {16'd0, iter16}, 32'd0);
    chk({tag, "_iter4"}, {28'd0, iter4}, 32'd0);
  endtask

  task automatic run_op(input vec_t v);
    int e;
    start = 1'b1;
    in_valid = 1'b0;
    tick();
    // edge 0 sampled start: now in LOAD_A
    start = 1'b0;
    data = v.a;
    in_valid = 1'b1;
    #1;
    chk("st_done_low", {31'd0, done16}, 32'd0);
    chk("st_iter16_clr", {16'd0, iter16}, 32'd0);
    chk("st_iter4_clr", {28'd0, iter4}, 32'd0);
    chk("la_ready_busy", {30'd0, rdy16, busy16}, 32'd3);
    chk("la_lda", {29'd0, lda16, ldb16, ldp16}, 32'd4);
    tick();
    e = 1;
    if (v.gap > 0) in_valid = 1'b0;
    for (int i = 0; i < v.gap; i++) begin
      #1;
      chk("gap_no_ldb", {30'd0, ldb16, clrp16}, 32'd0);
      chk("gap_ready", {31'd0, rdy16}, 32'd1);
      tick();
      e++;
    end
    data = v.b;
    in_valid = 1'b1;
    #1;
    chk("lb_ldb_clrp", {29'd0, lda16, ldb16, clrp16}, 32'd3);
    tick();
    e++;
    in_valid = 1'b0;
    data = '0;
    #1;
    while (!done16 && e < 400) begin
      if (v.abort != 0 && e == v.abort) begin
        rst = 1'b1;
        #1;
        chk_all_zero("rst_cycle");
        tick();
        rst = 1'b0;
        #1;
        chk("abort_p_kept", {16'd0, p16}, {16'd0, v.a * 16'(v.abort - 2)});
        chk("abort_idle", {29'd0, busy16, rdy16, done16}, 32'd0);
        chk("abort_iter", {16'd0, iter16}, 32'd0);
        return;
      end
      start = (v.poke && e == 4 + v.gap);
      tick();
      e++;
      start = 1'b0;
      #1;
      if (v.poke && e == 5 + v.gap) chk("poke_ignored", {30'd0, busy16, rdy16}, 32'd2);
    end
    chk("latency", e, 32'(3 + int'(v.b) + v.gap));
    chk("done4", {31'd0, done4}, 32'd1);
    chk("p16", {16'd0, p16}, {16'd0, v.exp_p});
    chk("p4", {16'd0, p4}, {16'd0, v.exp_p});
    chk("iter16", {16'd0, iter16}, 32'(v.exp_cnt16));
    chk("iter4", {28'd0, iter4}, 32'(v.exp_cnt4));
    tick();
    chk("done_holds", {30'd0, done16, busy16}, 32'd2);
  endtask

  initial begin
    vecs[0] = '{a: 16'd5,      b: 16'd3,   gap: 0, poke: 0, abort: 0,
                exp_p: 16'd15,     exp_cnt16: 3,  exp_cnt4: 3};
    vecs[1] = '{a: 16'd7,      b: 16'd0,   gap: 0, poke: 0, abort: 0,
                exp_p: 16'd0,      exp_cnt16: 0,  exp_cnt4: 0};
    vecs[2] = '{a: 16'd9,      b: 16'd4,   gap: 2, poke: 0, abort: 0,
                exp_p: 16'd36,     exp_cnt16: 4,  exp_cnt4: 4};
    vecs[3] = '{a: 16'd2,      b: 16'd100, gap: 0, poke: 0, abort: 12,
                exp_p: 16'd0,      exp_cnt16: 0,  exp_cnt4: 0};
    vecs[4] = '{a: 16'd3,      b: 16'd2,   gap: 0, poke: 0, abort: 0,
                exp_p: 16'd6,      exp_cnt16: 2,  exp_cnt4: 2};
    vecs[5] = '{a: 16'd1,      b: 16'd5,   gap: 0, poke: 1, abort: 0,
                exp_p: 16'd5,      exp_cnt16: 5,  exp_cnt4: 5};
    vecs[6] = '{a: 16'd1,      b: 16'd20,  gap: 0, poke: 0, abort: 0,
                exp_p: 16'd20,     exp_cnt16: 20, exp_cnt4: 15};
    vecs[7] = '{a: 16'hFFFF,   b: 16'd2,   gap: 0, poke: 0, abort: 0,
                exp_p: 16'hFFFE,   exp_cnt16: 2,  exp_cnt4: 2};

    // Reset with start/in_valid asserted: everything must stay quiet.
    rst = 1'b1;
    start = 1'b1;
    in_valid = 1'b1;
    data = 16'h1234;
    tick();
    tick();
    chk_all_zero("reset");
    rst = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("idle_after_reset", {29'd0, busy16, rdy16, done16}, 32'd0);
    tick();
    chk("idle_holds", {30'd0, busy16, lda16}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      run_op(vecs[i]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
